// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with lw load-use hazard detection.
// Captures the decode-stage controls, operands and register specifiers into EX.
// When the lw in EX writes a register that the instruction in ID reads, the stage
// inserts one bubble. It also keeps a saturating count of stall cycles.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   hold                           global freeze; the stage and the counter keep their state
//   id_* controls, ALU op          controller outputs for the instruction in ID
//   id_rd1, id_rd2, id_imm         register read data and sign-extended immediate
//   id_rs, id_rt, id_rd            register specifiers of the instruction in ID
//   ex_*                           registered copies of the id_* inputs
//   sel_cancel                     0 cancels the controller outputs (combinational)
//   pc_write, ifid_write           PC and IF/ID write enables (combinational)
//   stall_count                    saturating count of hazard-stall cycles
module id_ex_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 id_ALUSrc,
  input  logic                 id_regWrite,
  input  logic                 id_memWrite,
  input  logic                 id_memRead,
  input  logic                 id_memtoReg,
  input  logic                 id_regDst,
  input  logic [1:0]           id_ALUOperation,
  input  logic [WIDTH-1:0]     id_rd1,
  input  logic [WIDTH-1:0]     id_rd2,
  input  logic [WIDTH-1:0]     id_imm,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic [4:0]           id_rd,
  output logic                 ex_ALUSrc,
  output logic                 ex_regWrite,
  output logic                 ex_memWrite,
  output logic                 ex_memRead,
  output logic                 ex_memtoReg,
  output logic                 ex_regDst,
  output logic [1:0]           ex_ALUOperation,
  output logic [WIDTH-1:0]     ex_rd1,
  output logic [WIDTH-1:0]     ex_rd2,
  output logic [WIDTH-1:0]     ex_imm,
  output logic [4:0]           ex_rs,
  output logic [4:0]           ex_rt,
  output logic [4:0]           ex_rd,
  output logic                 sel_cancel,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic hazard;

  // The lw in EX targets a nonzero register that ID reads. An rt-only match
  // counts as well, because I-type instructions are treated conservatively.
  always_comb begin
    hazard     = ex_memRead && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    sel_cancel = ~hazard;
    pc_write   = ~hazard & ~hold;
    ifid_write = ~hazard & ~hold;
  end

  // Pipeline register. hold has priority over hazard, so a frozen stage never bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ALUSrc       <= 1'b0;
      ex_regWrite     <= 1'b0;
      ex_memWrite     <= 1'b0;
      ex_memRead      <= 1'b0;
      ex_memtoReg     <= 1'b0;
      ex_regDst       <= 1'b0;
      ex_ALUOperation <= 2'b00;
      ex_rd1          <= '0;
      ex_rd2          <= '0;
      ex_imm          <= '0;
      ex_rs           <= 5'd0;
      ex_rt           <= 5'd0;
      ex_rd           <= 5'd0;
      stall_count     <= '0;
    end else if (!hold) begin
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
      if (hazard) begin
        // Bubble: the controls are forced to zero whatever the controller drives.
        ex_ALUSrc       <= 1'b0;
        ex_regWrite     <= 1'b0;
        ex_memWrite     <= 1'b0;
        ex_memRead      <= 1'b0;
        ex_memtoReg     <= 1'b0;
        ex_regDst       <= 1'b0;
        ex_ALUOperation <= 2'b00;
        if (stall_count != {CNT_WIDTH{1'b1}})
          stall_count <= stall_count + CNT_WIDTH'(1);
      end else begin
        ex_ALUSrc       <= id_ALUSrc;
        ex_regWrite     <= id_regWrite;
        ex_memWrite     <= id_memWrite;
        ex_memRead      <= id_memRead;
        ex_memtoReg     <= id_memtoReg;
        ex_regDst       <= id_regDst;
        ex_ALUOperation <= id_ALUOperation;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. The counter is 2 bits wide so that saturation is reachable.
module tb_id_ex_stage;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CNT_WIDTH = 2;

  // Control vector layout: {ALUSrc, regWrite, memWrite, memRead, memtoReg, regDst, ALUOp[1:0]}
  localparam logic [7:0] C_NOP = 8'h00;
  localparam logic [7:0] C_LW  = 8'hD8;
  localparam logic [7:0] C_RT  = 8'h46;

  logic clk = 1'b0;
  logic rst_n;
  logic hold;
  logic [7:0] id_ctrl;
  logic [WIDTH-1:0] id_rd1, id_rd2, id_imm;
  logic [4:0] id_rs, id_rt, id_rd;

  logic ex_ALUSrc, ex_regWrite, ex_memWrite, ex_memRead, ex_memtoReg, ex_regDst;
  logic [1:0] ex_ALUOperation;
  logic [WIDTH-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic sel_cancel, pc_write, ifid_write;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [7:0] ex_ctrl;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [CNT_WIDTH-1:0] exp_cnt;

  assign ex_ctrl = {ex_ALUSrc, ex_regWrite, ex_memWrite, ex_memRead,
                    ex_memtoReg, ex_regDst, ex_ALUOperation};

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .id_ALUSrc(id_ctrl[7]), .id_regWrite(id_ctrl[6]), .id_memWrite(id_ctrl[5]),
    .id_memRead(id_ctrl[4]), .id_memtoReg(id_ctrl[3]), .id_regDst(id_ctrl[2]),
    .id_ALUOperation(id_ctrl[1:0]),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite), .ex_memWrite(ex_memWrite),
    .ex_memRead(ex_memRead), .ex_memtoReg(ex_memtoReg), .ex_regDst(ex_regDst),
    .ex_ALUOperation(ex_ALUOperation),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .sel_cancel(sel_cancel), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_count(stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [WIDTH-1:0] d1,
                       input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] im);
    id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = d1; id_rd2 = d2; id_imm = im;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    #12 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            32'($urandom), 32'($urandom), 32'($urandom));
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ex_ctrl !== 8'h00) $display("FAIL reset_ctrl got %h want 00", ex_ctrl);
    else pass_cnt++;
    total_cnt++;
    if ({ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} !== '0)
      $display("FAIL reset_data got %h %h %h %0d %0d %0d want all 0",
               ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== 2'd0) $display("FAIL reset_count got %0d want 0", stall_count);
    else pass_cnt++;
    total_cnt++;
    if ({sel_cancel, pc_write, ifid_write} !== 3'b111)
      $display("FAIL reset_enables got %b want 111", {sel_cancel, pc_write, ifid_write});
    else pass_cnt++;
    hold = 1'b1;
    #1;
    total_cnt++;
    if ({sel_cancel, pc_write, ifid_write} !== 3'b100)
      $display("FAIL reset_hold_enables got %b want 100", {sel_cancel, pc_write, ifid_write});
    else pass_cnt++;
    hold = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    tick();
    #2 rst_n = 1'b1;
    exp_cnt = 2'd0;
    tick();
  endtask

  task automatic test_load_use();
    drive(C_LW, 5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'h4);
    tick();
    total_cnt++;
    if (ex_ctrl !== C_LW || ex_rt !== 5'd2)
      $display("FAIL lu_lw_in_ex got ctrl=%h rt=%0d want ctrl=%h rt=2", ex_ctrl, ex_rt, C_LW);
    else pass_cnt++;
    drive(C_RT, 5'd2, 5'd3, 5'd4, 32'hAA, 32'hBB, 32'h0);
    #1;
    total_cnt++;
    if ({sel_cancel, pc_write, ifid_write} !== 3'b000)
      $display("FAIL lu_detect got %b want 000", {sel_cancel, pc_write, ifid_write});
    else pass_cnt++;
    tick();
    if (exp_cnt != 2'd3) exp_cnt++;
    total_cnt++;
    if (ex_ctrl !== 8'h00 || ex_rs !== 5'd2 || ex_rd1 !== 32'hAA)
      $display("FAIL lu_bubble got ctrl=%h rs=%0d rd1=%h want ctrl=00 rs=2 rd1=000000aa",
               ex_ctrl, ex_rs, ex_rd1);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== exp_cnt) $display("FAIL lu_count got %0d want %0d", stall_count, exp_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({sel_cancel, pc_write} !== 2'b11)
      $display("FAIL lu_release got %b want 11", {sel_cancel, pc_write});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_ctrl !== C_RT || ex_rd !== 5'd4 || stall_count !== exp_cnt)
      $display("FAIL lu_advance got ctrl=%h rd=%0d cnt=%0d want ctrl=%h rd=4 cnt=%0d",
               ex_ctrl, ex_rd, stall_count, C_RT, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_no_hazard();
    drive(C_LW, 5'd0, 5'd0, 5'd0, '0, '0, 32'h8);
    tick();
    drive(C_RT, 5'd0, 5'd0, 5'd5, '0, '0, '0);
    #1;
    total_cnt++;
    if ({sel_cancel, pc_write} !== 2'b11)
      $display("FAIL nh_detect got %b want 11", {sel_cancel, pc_write});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_ctrl !== C_RT || stall_count !== exp_cnt)
      $display("FAIL nh_pass got ctrl=%h cnt=%0d want ctrl=%h cnt=%0d",
               ex_ctrl, stall_count, C_RT, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_pass_through();
    drive(C_RT, 5'd5, 5'd6, 5'd7, 32'h1234, 32'hABCD, 32'hFFFF_FFF0);
    tick();
    total_cnt++;
    if (ex_ctrl !== C_RT || ex_rd1 !== 32'h1234 || ex_rd2 !== 32'hABCD ||
        ex_imm !== 32'hFFFF_FFF0 || ex_rs !== 5'd5 || ex_rt !== 5'd6 || ex_rd !== 5'd7)
      $display("FAIL pt_fields got %h %h %h %h %0d %0d %0d want 46 00001234 0000abcd fffffff0 5 6 7",
               ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd);
    else pass_cnt++;
    total_cnt++;
    if (stall_count !== exp_cnt) $display("FAIL pt_count got %0d want %0d", stall_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    drive(C_LW, 5'd1, 5'd9, 5'd0, '0, '0, '0);
    tick();
    drive(C_RT, 5'd9, 5'd1, 5'd3, 32'h55, '0, '0);
    hold = 1'b1;
    #1;
    total_cnt++;
    if ({sel_cancel, pc_write, ifid_write} !== 3'b000)
      $display("FAIL hold_enables got %b want 000", {sel_cancel, pc_write, ifid_write});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (ex_ctrl !== C_LW || ex_rt !== 5'd9 || stall_count !== exp_cnt)
        $display("FAIL hold_frozen_%0d got ctrl=%h rt=%0d cnt=%0d want ctrl=%h rt=9 cnt=%0d",
                 i, ex_ctrl, ex_rt, stall_count, C_LW, exp_cnt);
      else pass_cnt++;
    end
    hold = 1'b0;
    #1;
    total_cnt++;
    if (pc_write !== 1'b0) $display("FAIL hold_release_pc got %b want 0", pc_write);
    else pass_cnt++;
    tick();
    if (exp_cnt != 2'd3) exp_cnt++;
    total_cnt++;
    if (ex_ctrl !== 8'h00 || stall_count !== exp_cnt)
      $display("FAIL hold_bubble got ctrl=%h cnt=%0d want ctrl=00 cnt=%0d",
               ex_ctrl, stall_count, exp_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_ctrl !== C_RT || ex_rd1 !== 32'h55 || stall_count !== exp_cnt)
      $display("FAIL hold_advance got ctrl=%h rd1=%h cnt=%0d want ctrl=%h rd1=00000055 cnt=%0d",
               ex_ctrl, ex_rd1, stall_count, C_RT, exp_cnt);
    else pass_cnt++;
  endtask

  // Alternates rs and rt matches. The count must stop at 3.
  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(C_LW, 5'd1, 5'd3, 5'd0, '0, '0, '0);
      tick();
      if (i % 2 == 0) drive(C_RT, 5'd3, 5'd8, 5'd9, '0, '0, '0);
      else            drive(C_RT, 5'd8, 5'd3, 5'd9, '0, '0, '0);
      tick();
      if (exp_cnt != 2'd3) exp_cnt++;
      total_cnt++;
      if (stall_count !== exp_cnt || ex_ctrl !== 8'h00)
        $display("FAIL sat_pair_%0d got cnt=%0d ctrl=%h want cnt=%0d ctrl=00",
                 i, stall_count, ex_ctrl, exp_cnt);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_count !== 2'd3) $display("FAIL sat_final got %0d want 3", stall_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    drive(C_LW, 5'd1, 5'd4, 5'd0, '0, '0, '0);
    tick();
    drive(C_RT, 5'd4, 5'd2, 5'd6, '0, '0, '0);
    #1;
    total_cnt++;
    if (pc_write !== 1'b0) $display("FAIL rms_stall got %b want 0", pc_write);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    exp_cnt = 2'd0;
    total_cnt++;
    if ({sel_cancel, pc_write, ifid_write} !== 3'b111 || stall_count !== 2'd0 || ex_ctrl !== 8'h00)
      $display("FAIL rms_clear got en=%b cnt=%0d ctrl=%h want en=111 cnt=0 ctrl=00",
               {sel_cancel, pc_write, ifid_write}, stall_count, ex_ctrl);
    else pass_cnt++;
    #3 rst_n = 1'b1;
    tick();
    total_cnt++;
    if (ex_ctrl !== C_RT || stall_count !== exp_cnt)
      $display("FAIL rms_resume got ctrl=%h cnt=%0d want ctrl=%h cnt=%0d",
               ex_ctrl, stall_count, C_RT, exp_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_pass_through();
    test_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
